// File: rtl/arc4_phase_controller_pkg.sv
// Shared types and defaults for the ARC4 phase controller slice.
package arc4_pkg;

  localparam int DEF_KEY_W = 24;
  localparam int DEF_AW    = 8;
  localparam int DEF_DW    = 8;

  localparam int ENG_INIT = 0;
  localparam int ENG_KSA  = 1;
  localparam int ENG_PRGA = 2;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLR,
    RUN_INIT,
    RUN_KSA,
    RUN_PRGA,
    NEXT,
    FOUND,
    FAIL,
    TOERR
  } phase_t;

  // Engine that owns s_mem in a given phase; 2'd3 means nobody does.
  function automatic logic [1:0] owner_of(input phase_t p);
    case (p)
      RUN_INIT: owner_of = 2'(ENG_INIT);
      RUN_KSA:  owner_of = 2'(ENG_KSA);
      RUN_PRGA: owner_of = 2'(ENG_PRGA);
      default:  owner_of = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/arc4_phase_controller_if.sv
// Control and memory-request bundle between the phase controller and its three engines.
interface arc4_phase_controller_if
  import arc4_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic [2:0]      eng_reset;
  logic [2:0]      eng_start;
  logic [2:0]      eng_done;
  logic            prga_ok;
  logic [3*AW-1:0] eng_addr;
  logic [3*DW-1:0] eng_wdata;
  logic [2:0]      eng_wren;

  modport master (
    output eng_reset, eng_start,
    input  eng_done, prga_ok, eng_addr, eng_wdata, eng_wren
  );

  modport slave (
    input  eng_reset, eng_start,
    output eng_done, prga_ok, eng_addr, eng_wdata, eng_wren
  );

endinterface

// File: rtl/arc4_phase_controller_s_mem_mux.sv
// Routes the owning engine's request to the single-port S memory; owner 3 drives zeros.
module s_mem_mux #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic [1:0]      owner,
  input  logic [3*AW-1:0] eng_addr,
  input  logic [3*DW-1:0] eng_wdata,
  input  logic [2:0]      eng_wren,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic            s_wren
);

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    if (owner != 2'd3) begin
      s_addr  = eng_addr[int'(owner)*AW +: AW];
      s_wdata = eng_wdata[int'(owner)*DW +: DW];
      s_wren  = eng_wren[owner];
    end
  end

endmodule

// File: rtl/arc4_phase_controller.sv
// Sequences init/KSA/PRGA engines per candidate key and brute-forces the key range.
module arc4_phase_controller
  import arc4_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int KEY_STEP = 1,
  parameter int TIMEOUT  = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_W-1:0]       key_first,
  input  logic [KEY_W-1:0]       key_last,
  output logic [KEY_W-1:0]       secret_key,
  arc4_phase_controller_if.master eng,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_wdata,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   found,
  output logic                   exhausted,
  output logic                   timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [KEY_W-1:0] STEP    = KEY_W'(KEY_STEP);

  phase_t          state, next_state;
  logic [WD_W-1:0] wdog;
  logic [1:0]      owner;
  logic            first_cycle;
  logic            owner_done;
  logic            last_key;

  assign owner       = owner_of(state);
  assign first_cycle = (wdog == '0);
  assign owner_done  = |(eng.eng_done & (3'b001 << owner));
  assign last_key    = (secret_key >= key_last) || ((key_last - secret_key) < STEP);

  // Next-state and strobe decode; outputs depend on state only, so reset clears them at once.
  always_comb begin
    next_state    = state;
    eng.eng_reset = 3'b000;
    eng.eng_start = 3'b000;
    busy          = 1'b0;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        busy       = 1'b1;
        next_state = (key_first > key_last) ? FAIL : CLR;
      end
      CLR: begin
        busy          = 1'b1;
        eng.eng_reset = 3'b111;
        next_state    = RUN_INIT;
      end
      RUN_INIT, RUN_KSA, RUN_PRGA: begin
        busy = 1'b1;
        if (first_cycle) begin
          eng.eng_start = 3'(3'b001 << owner);
        end else if (owner_done) begin
          case (state)
            RUN_INIT: next_state = RUN_KSA;
            RUN_KSA:  next_state = RUN_PRGA;
            default:  next_state = eng.prga_ok ? FOUND : NEXT;
          endcase
        end else if (wdog == WD_LAST) begin
          next_state = TOERR;
        end
      end
      NEXT: begin
        busy       = 1'b1;
        next_state = last_key ? FAIL : CLR;
      end
      FOUND, FAIL, TOERR: if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Watchdog restarts on every phase change, so it reads zero in the first cycle of each RUN phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wdog        <= '0;
      secret_key  <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wdog <= '0;
      else if (owner != 2'd3)
        wdog <= wdog + 1'b1;

      if (state == IDLE && start) begin
        found       <= 1'b0;
        exhausted   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state == LOAD)
        secret_key <= key_first;
      if (state == NEXT && !last_key)
        secret_key <= secret_key + STEP;

      if (next_state == FOUND && state != FOUND) found       <= 1'b1;
      if (next_state == FAIL  && state != FAIL)  exhausted   <= 1'b1;
      if (next_state == TOERR && state != TOERR) timeout_err <= 1'b1;
    end
  end

  s_mem_mux #(.AW(AW), .DW(DW)) u_mux (
    .owner     (owner),
    .eng_addr  (eng.eng_addr),
    .eng_wdata (eng.eng_wdata),
    .eng_wren  (eng.eng_wren),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wren    (s_wren)
  );

endmodule

// File: tb/tb_arc4_phase_controller.sv
// Directed bench with stub engines and a result/start-order scoreboard for arc4_phase_controller.
module tb_arc4_phase_controller;

  localparam int TIMEOUT = 4095;

  typedef struct {
    logic        found;
    logic        exhausted;
    logic        tmo;
    logic [23:0] key;
    int          clears;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key_first = '0;
  logic [23:0] key_last = '0;
  logic [23:0] secret_key;
  logic [7:0]  s_addr, s_wdata;
  logic        s_wren, busy, found, exhausted, timeout_err;

  bit          ksa_hang = 1'b0;
  bit          ok_en = 1'b0;
  logic [23:0] ok_key = '0;
  logic [2:0]  done_r;
  int          cnt [3];

  int checks = 0, errors = 0;
  int clr_count = 0, clr_base = 0, cyc = 0, ksa_cyc = 0, prga_age = 0;
  logic tmo_prev = 1'b0;
  int   exp_start_q[$];
  exp_t exp_q[$];

  arc4_phase_controller_if eng ();

  arc4_phase_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_first   (key_first),
    .key_last    (key_last),
    .secret_key  (secret_key),
    .eng         (eng),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wren      (s_wren),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout observed=still_running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  function automatic int lat(input int n);
    case (n)
      0:       return 256;
      1:       return 768;
      default: return 64;
    endcase
  endfunction

  function automatic exp_t mkExp(input logic f, input logic x, input logic t,
                                 input logic [23:0] k, input int c);
    exp_t e;
    e.found = f; e.exhausted = x; e.tmo = t; e.key = k; e.clears = c;
    return e;
  endfunction

  // Stub engines: done rises a fixed latency after start and stays until cleared.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r <= 3'b000;
      for (int n = 0; n < 3; n++) cnt[n] <= 0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (eng.eng_reset[n]) begin
          done_r[n] <= 1'b0;
          cnt[n]    <= 0;
        end else if (eng.eng_start[n]) begin
          cnt[n] <= (n == 1 && ksa_hang) ? 0 : lat(n);
        end else if (cnt[n] > 1) begin
          cnt[n] <= cnt[n] - 1;
        end else if (cnt[n] == 1) begin
          cnt[n]    <= 0;
          done_r[n] <= 1'b1;
        end
      end
    end
  end

  assign eng.eng_done  = done_r;
  assign eng.prga_ok   = ok_en && (secret_key == ok_key);
  assign eng.eng_addr  = {8'hA2, 8'hA1, 8'hA0};
  assign eng.eng_wdata = {8'h32, 8'h31, 8'h30};
  assign eng.eng_wren  = 3'b111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Protocol monitor: start order, arbitration in CLR/NEXT/first RUN cycles, timeout latency.
  always @(negedge clk) begin
    if (!reset) begin
      if (eng.eng_reset != 3'b000) begin
        clr_count <= clr_count + 1;
        checkOutput("clr_eng_reset", 32'(eng.eng_reset), 32'h7);
        checkOutput("clr_s_wren", 32'(s_wren), 32'h0);
        checkOutput("clr_s_addr", 32'(s_addr), 32'h0);
      end
      for (int n = 0; n < 3; n++) begin
        if (eng.eng_start[n]) begin
          if (exp_start_q.size() == 0) checkOutput("start_unexpected", 32'(n), 32'h9);
          else checkOutput("start_order", 32'(n), 32'(exp_start_q.pop_front()));
          checkOutput("start_s_addr", 32'(s_addr), 32'hA0 + 32'(n));
          checkOutput("start_s_wdata", 32'(s_wdata), 32'h30 + 32'(n));
          checkOutput("start_s_wren", 32'(s_wren), 32'h1);
          if (n == 1) ksa_cyc <= cyc;
        end
      end
      prga_age <= eng.eng_done[2] ? prga_age + 1 : 0;
      if (eng.eng_done[2] && prga_age == 1) begin
        if (eng.prga_ok) begin
          checkOutput("found_busy", 32'(busy), 32'h0);
          checkOutput("found_flag", 32'(found), 32'h1);
        end else begin
          checkOutput("next_busy", 32'(busy), 32'h1);
          checkOutput("next_s_wren", 32'(s_wren), 32'h0);
          checkOutput("next_s_addr", 32'(s_addr), 32'h0);
        end
      end
      if (timeout_err && !tmo_prev)
        checkOutput("timeout_latency", 32'(cyc - ksa_cyc), 32'(TIMEOUT));
      tmo_prev <= timeout_err;
    end
  end

  task automatic applyStimulus(input logic [23:0] kf, input logic [23:0] kl, input logic [23:0] okk,
                               input bit oke, input bit hang, input exp_t e, input int n_starts);
    key_first = kf;
    key_last  = kl;
    ok_key    = okk;
    ok_en     = oke;
    ksa_hang  = hang;
    clr_base  = clr_count;
    exp_q.push_back(e);
    for (int i = 0; i < n_starts; i++) exp_start_q.push_back(i % 3);
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic waitBusy(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (busy === level);
    end
  endtask

  task automatic finishRun();
    bit   ok;
    exp_t e;
    waitBusy(1'b1, 20, ok);
    checkOutput("busy_rise", 32'(ok), 32'h1);
    waitBusy(1'b0, 20000, ok);
    checkOutput("busy_fall", 32'(ok), 32'h1);
    e = exp_q.pop_front();
    checkOutput("result_found", 32'(found), 32'(e.found));
    checkOutput("result_exhausted", 32'(exhausted), 32'(e.exhausted));
    checkOutput("result_timeout", 32'(timeout_err), 32'(e.tmo));
    checkOutput("result_key", 32'(secret_key), 32'(e.key));
    checkOutput("clr_pulses", 32'(clr_count - clr_base), 32'(e.clears));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_flags_held", 32'({found, exhausted, timeout_err}), 32'({e.found, e.exhausted, e.tmo}));
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_key_held", 32'(secret_key), 32'(e.key));
    checkOutput("starts_consumed", 32'(exp_start_q.size()), 32'h0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_key", 32'(secret_key), 32'h0);
    checkOutput("rst_flags", 32'({found, exhausted, timeout_err}), 32'h0);
    checkOutput("rst_s_wren", 32'(s_wren), 32'h0);
    checkOutput("rst_strobes", 32'({eng.eng_reset, eng.eng_start}), 32'h0);

    $display("[TB] single key");
    applyStimulus(24'h000249, 24'h000249, 24'h000249, 1'b1, 1'b0, mkExp(1, 0, 0, 24'h000249, 1), 3);
    finishRun();

    $display("[TB] search 0..5, match on 3");
    applyStimulus(24'd0, 24'd5, 24'd3, 1'b1, 1'b0, mkExp(1, 0, 0, 24'd3, 4), 12);
    finishRun();

    $display("[TB] exhaust 0..2");
    applyStimulus(24'd0, 24'd2, 24'd0, 1'b0, 1'b0, mkExp(0, 1, 0, 24'd2, 3), 9);
    finishRun();

    $display("[TB] inverted range");
    applyStimulus(24'd5, 24'd2, 24'd0, 1'b0, 1'b0, mkExp(0, 1, 0, 24'd5, 0), 0);
    finishRun();

    $display("[TB] KSA timeout");
    applyStimulus(24'd7, 24'd7, 24'd0, 1'b0, 1'b1, mkExp(0, 0, 1, 24'd7, 1), 2);
    finishRun();

    $display("[TB] reset during KSA write");
    ksa_hang  = 1'b0;
    key_first = 24'h000011;
    key_last  = 24'h000011;
    ok_key    = 24'h000011;
    ok_en     = 1'b1;
    for (int i = 0; i < 3; i++) exp_start_q.push_back(i);
    @(negedge clk);
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = eng.eng_start[1];
    end
    checkOutput("reach_ksa", 32'(seen), 32'h1);
    repeat (5) @(negedge clk);
    checkOutput("ksa_s_addr", 32'(s_addr), 32'hA1);
    checkOutput("ksa_s_wdata", 32'(s_wdata), 32'h31);
    checkOutput("ksa_s_wren", 32'(s_wren), 32'h1);
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    checkOutput("arst_s_wren", 32'(s_wren), 32'h0);
    checkOutput("arst_s_addr", 32'(s_addr), 32'h0);
    checkOutput("arst_s_wdata", 32'(s_wdata), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_key", 32'(secret_key), 32'h0);
    checkOutput("arst_flags", 32'({found, exhausted, timeout_err}), 32'h0);
    checkOutput("arst_strobes", 32'({eng.eng_reset, eng.eng_start}), 32'h0);
    exp_start_q.delete();
    @(negedge clk);
    #2;
    reset = 1'b0;

    $display("[TB] restart after reset");
    applyStimulus(24'h000040, 24'h000040, 24'h000040, 1'b1, 1'b0, mkExp(1, 0, 0, 24'h000040, 1), 3);
    finishRun();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
